// File: rtl/layer_mem_arb_pkg.sv
// Shared definitions for the layer memory arbiter, the conv engine and the host readout.
package layer_mem_arb_pkg;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 13;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/layer_mem_rtag.sv
// Read return path: carries {valid, requester id} alongside each read and routes cdata_rd back.
module layer_mem_rtag
    import layer_mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              vld_p0,
    input  logic              id_p0,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);

    logic vld_p1, id_p1;
    logic vld_p2, id_p2;

    // p0 -> p1: read strobe cycle; p1 -> p2: memory data cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            id_p1  <= 1'b0;
            vld_p2 <= 1'b0;
            id_p2  <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            id_p1  <= id_p0;
            vld_p2 <= vld_p1;
            id_p2  <= id_p1;
        end
    end

    assign rvalid0 = vld_p2 & ~id_p2;
    assign rvalid1 = vld_p2 &  id_p2;
    assign rdata0  = rvalid0 ? cdata_rd : '0;
    assign rdata1  = rvalid1 ? cdata_rd : '0;

endmodule

// File: rtl/layer_mem_arb.sv
// Two-requester arbiter for the layer memory: conv engine (0) vs host readout (1), burst lock with bounded hold.
module layer_mem_arb
    import layer_mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic              sel0,
    input  logic              sel1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              csel
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_t       state, state_nxt;
    logic             last_owner, last_owner_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [CNT_W-1:0] hold_inc;
    logic             hold_room;
    logic             g0, g1;

    assign hold_room = (hold_cnt < CNT_W'(MAX_HOLD));
    assign hold_inc  = (hold_cnt == CNT_W'(MAX_HOLD)) ? hold_cnt : hold_cnt + CNT_W'(1);

    // The hold limit only bites when the other side is waiting
    always_comb begin
        g0             = 1'b0;
        g1             = 1'b0;
        state_nxt      = IDLE;
        last_owner_nxt = last_owner;
        hold_cnt_nxt   = '0;
        case (state)
            OWN0: begin
                if (req0 && lock0 && (hold_room || !req1)) g0 = 1'b1;
                else if (req1)                             g1 = 1'b1;
                else if (req0)                             g0 = 1'b1;
            end
            OWN1: begin
                if (req1 && lock1 && (hold_room || !req0)) g1 = 1'b1;
                else if (req0)                             g0 = 1'b1;
                else if (req1)                             g1 = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    g0 = last_owner;
                    g1 = ~last_owner;
                end else begin
                    g0 = req0;
                    g1 = req1;
                end
            end
        endcase
        if (g0) begin
            state_nxt      = OWN0;
            last_owner_nxt = 1'b0;
            hold_cnt_nxt   = (state == OWN0) ? hold_inc : CNT_W'(1);
        end else if (g1) begin
            state_nxt      = OWN1;
            last_owner_nxt = 1'b1;
            hold_cnt_nxt   = (state == OWN1) ? hold_inc : CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            hold_cnt   <= hold_cnt_nxt;
        end
    end

    assign gnt0 = g0 & ~reset;
    assign gnt1 = g1 & ~reset;

    logic              acc_p0, wr_p0, rd_p0, sel_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    assign acc_p0   = (req0 & gnt0) | (req1 & gnt1);
    assign wr_p0    = acc_p0 & (gnt1 ? we1 : we0);
    assign rd_p0    = acc_p0 & ~(gnt1 ? we1 : we0);
    assign sel_p0   = gnt1 ? sel1 : sel0;
    assign addr_p0  = gnt1 ? addr1 : addr0;
    assign wdata_p0 = gnt1 ? wdata1 : wdata0;

    // p0 -> p1: accepted access becomes a memory strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwr      <= 1'b0;
            crd      <= 1'b0;
            csel     <= 1'b0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            caddr_rd <= '0;
        end else begin
            cwr <= wr_p0;
            crd <= rd_p0;
            if (acc_p0) csel <= sel_p0;
            if (wr_p0) begin
                caddr_wr <= addr_p0;
                cdata_wr <= wdata_p0;
            end
            if (rd_p0) caddr_rd <= addr_p0;
        end
    end

    layer_mem_rtag u_rtag (
        .clk      (clk),
        .reset    (reset),
        .vld_p0   (rd_p0),
        .id_p0    (gnt1),
        .cdata_rd (cdata_rd),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1)
    );

endmodule

// File: tb/tb_layer_mem_arb.sv
// Directed bench for layer_mem_arb with a simple memory model driving cdata_rd.
module tb_layer_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, lock0, lock1, we0, we1, sel0, sel1;
    logic [11:0] addr0, addr1;
    logic [12:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [12:0] rdata0, rdata1;
    logic        cwr, crd, csel;
    logic [11:0] caddr_wr, caddr_rd;
    logic [12:0] cdata_wr, cdata_rd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    layer_mem_arb #(.MAX_HOLD(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .sel0(sel0), .sel1(sel1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
    );

    // Memory returns {sel,addr} + 0x123 the cycle after a read strobe, junk otherwise
    always @(posedge clk) cdata_rd <= crd ? ({csel, caddr_rd} + 13'h0123) : 13'h1FFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".gnt0"}, gnt0, 0);
        chk({tag, ".gnt1"}, gnt1, 0);
        chk({tag, ".rvalid0"}, rvalid0, 0);
        chk({tag, ".rvalid1"}, rvalid1, 0);
        chk({tag, ".rdata0"}, rdata0, 0);
        chk({tag, ".rdata1"}, rdata1, 0);
        chk({tag, ".cwr"}, cwr, 0);
        chk({tag, ".crd"}, crd, 0);
        chk({tag, ".csel"}, csel, 0);
        chk({tag, ".caddr_wr"}, caddr_wr, 0);
        chk({tag, ".caddr_rd"}, caddr_rd, 0);
        chk({tag, ".cdata_wr"}, cdata_wr, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        sel0 = 0; sel1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("gnt_onehot", gnt0 & gnt1, 0);
            chk("strobe_excl", cwr & crd, 0);
        end
    end

    initial begin
        int n0;
        logic [12:0] exp_d;
        logic gj;

        // Reset with requests active: grants must stay low
        clr(); reset = 1; req0 = 1; req1 = 1;
        tick(); tick(); #1;
        chk_zero("reset");
        clr();
        tick(); reset = 0;

        // Simultaneous reads after reset: engine first, data 2 cycles later
        tick(); req0 = 1; req1 = 1; addr0 = 12'h000; sel0 = 0; addr1 = 12'h005; sel1 = 1; #1;
        chk("first.gnt0", gnt0, 1);
        chk("first.gnt1", gnt1, 0);
        tick(); req0 = 0; #1;
        chk("second.gnt1", gnt1, 1);
        chk("second.gnt0", gnt0, 0);
        chk("rd0.crd", crd, 1);
        chk("rd0.caddr_rd", caddr_rd, 12'h000);
        chk("rd0.csel", csel, 0);
        chk("rd0.cwr", cwr, 0);
        tick(); req1 = 0; #1;
        chk("rv0.rvalid0", rvalid0, 1);
        chk("rv0.rdata0", rdata0, 13'h0123);
        chk("rv0.rvalid1", rvalid1, 0);
        chk("rv0.rdata1", rdata1, 0);
        chk("rd1.crd", crd, 1);
        chk("rd1.caddr_rd", caddr_rd, 12'h005);
        chk("rd1.csel", csel, 1);
        tick(); #1;
        chk("rv1.rvalid1", rvalid1, 1);
        chk("rv1.rdata1", rdata1, 13'h1128);
        chk("rv1.rvalid0", rvalid0, 0);
        chk("rv1.rdata0", rdata0, 0);
        chk("rv1.crd", crd, 0);

        // Engine write to L1
        tick(); req0 = 1; we0 = 1; sel0 = 1; addr0 = 12'd1023; wdata0 = 13'h0FF0; #1;
        chk("wr.gnt0", gnt0, 1);
        tick(); clr(); #1;
        chk("wr.cwr", cwr, 1);
        chk("wr.csel", csel, 1);
        chk("wr.caddr_wr", caddr_wr, 12'd1023);
        chk("wr.cdata_wr", cdata_wr, 13'h0FF0);
        chk("wr.crd", crd, 0);
        chk("wr.gnt0_off", gnt0, 0);
        // Bus changes without req are ignored
        tick(); addr0 = 12'h123; wdata0 = 13'h0AAA; we0 = 1; sel0 = 0; #1;
        chk("wr_end.cwr", cwr, 0);
        chk("noreq.gnt0", gnt0, 0);
        tick(); clr(); #1;
        chk("noreq.cwr", cwr, 0);
        chk("noreq.caddr_wr", caddr_wr, 12'd1023);
        chk("noreq.cdata_wr", cdata_wr, 13'h0FF0);
        chk("noreq.csel", csel, 1);

        // Locked engine burst against a waiting host: 16 grants then handover
        tick(); reset = 1; #1;
        chk_zero("reset_pulse");
        tick(); reset = 0;
        n0 = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); req0 = 1; lock0 = 1; req1 = 1; addr0 = 12'(i); addr1 = 12'h100; #1;
            chk($sformatf("burst%0d.gnt0", i), gnt0, (i != 16));
            chk($sformatf("burst%0d.gnt1", i), gnt1, (i == 16));
            if (i < 17 && gnt0) n0++;
        end
        chk("burst.count0", n0, 16);
        tick(); clr();
        tick(); tick();

        // Round-robin reads, both requesting, unlocked
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k < 8) begin
                req0 = 1; req1 = 1; sel0 = 0; sel1 = 1;
                addr0 = 12'h010 + 12'(k); addr1 = 12'h020 + 12'(k);
            end else clr();
            #1;
            if (k < 8) begin
                chk($sformatf("rr%0d.gnt0", k), gnt0, (k % 2 == 1));
                chk($sformatf("rr%0d.gnt1", k), gnt1, (k % 2 == 0));
            end
            if (k >= 2) begin
                gj = ((k - 2) % 2 == 0);
                exp_d = gj ? 13'h1143 + 13'(k - 2) : 13'h0133 + 13'(k - 2);
                chk($sformatf("rr%0d.rvalid0", k), rvalid0, !gj);
                chk($sformatf("rr%0d.rvalid1", k), rvalid1, gj);
                chk($sformatf("rr%0d.rdata0", k), rdata0, gj ? 13'h0 : exp_d);
                chk($sformatf("rr%0d.rdata1", k), rdata1, gj ? exp_d : 13'h0);
            end
        end

        // Unchallenged owner holds past MAX_HOLD; a late challenger wins at once
        for (int i = 0; i < 21; i++) begin
            tick(); req0 = 1; lock0 = 1; req1 = (i == 20); addr0 = 12'(i); #1;
            chk($sformatf("solo%0d.gnt0", i), gnt0, (i < 20));
            chk($sformatf("solo%0d.gnt1", i), gnt1, (i == 20));
        end
        tick(); clr();
        tick(); tick();

        // Reset one cycle after a read acceptance drops the read
        tick(); req0 = 1; addr0 = 12'h055; #1;
        chk("mid.gnt0", gnt0, 1);
        tick(); clr(); reset = 1; #1;
        chk_zero("mid_reset");
        tick(); reset = 0;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk_zero($sformatf("post_reset%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
